// File: rtl/hdmi_tmds_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdmi_tmds_encoder: RGB565 + syncs to three DVI TMDS symbols, 3-clk latency|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hdmi_tmds_encoder #(
  parameter int EXPAND_MODE = 1
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic [15:0] rgb_i,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [9:0]  tmds_ch0_o,
  output logic [9:0]  tmds_ch1_o,
  output logic [9:0]  tmds_ch2_o
);

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Bit 8 of the result flags XOR (1) versus XNOR (0) chaining.
  function automatic logic [8:0] min_transitions(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_00;
      2'b01:   t = TOKEN_01;
      2'b10:   t = TOKEN_10;
      default: t = TOKEN_11;
    endcase
    return t;
  endfunction

  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;

  generate
    if (EXPAND_MODE == 1) begin : g_exp_msb
      assign r8 = {rgb_i[15:11], rgb_i[15:13]};
      assign g8 = {rgb_i[10:5],  rgb_i[10:9]};
      assign b8 = {rgb_i[4:0],   rgb_i[4:2]};
    end else begin : g_exp_zero
      assign r8 = {rgb_i[15:11], 3'b000};
      assign g8 = {rgb_i[10:5],  2'b00};
      assign b8 = {rgb_i[4:0],   3'b000};
    end
  endgenerate

  logic [7:0] ch_data [3];
  logic [1:0] ch_ctrl [3];
  logic [9:0] ch_sym  [3];

  assign ch_data[0] = b8;
  assign ch_data[1] = g8;
  assign ch_data[2] = r8;
  assign ch_ctrl[0] = {vsync_i, hsync_i};
  assign ch_ctrl[1] = 2'b00;
  assign ch_ctrl[2] = 2'b00;

  generate
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      logic [7:0]        s1_d;
      logic              s1_de;
      logic [1:0]        s1_c;
      logic [8:0]        qm;
      logic [8:0]        s2_qm;
      logic [3:0]        s2_n1;
      logic              s2_de;
      logic [1:0]        s2_c;
      logic signed [4:0] cnt;
      logic [9:0]        sym;
      logic signed [5:0] cnt_ext;
      logic signed [5:0] bal;
      logic signed [5:0] two;
      logic signed [5:0] cnt_nxt;
      logic [9:0]        sym_nxt;

      assign qm = min_transitions(s1_d);

      always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
          s1_d  <= '0;
          s1_de <= 1'b0;
          s1_c  <= '0;
          s2_qm <= '0;
          s2_n1 <= '0;
          s2_de <= 1'b0;
          s2_c  <= '0;
        end else begin
          s1_d  <= ch_data[ch];
          s1_de <= de_i;
          s1_c  <= ch_ctrl[ch];
          s2_qm <= qm;
          s2_n1 <= ones8(qm[7:0]);
          s2_de <= s1_de;
          s2_c  <= s1_c;
        end
      end

      // bal = N1q - N0q = 2*N1q - 8; two = 2*q_m[8].
      always_comb begin
        cnt_ext = {cnt[4], cnt};
        bal     = $signed({1'b0, s2_n1, 1'b0}) - 6'sd8;
        two     = s2_qm[8] ? 6'sd2 : 6'sd0;
        sym_nxt = ctrl_token(s2_c);
        cnt_nxt = '0;
        if (s2_de) begin
          if ((cnt == 5'sd0) || (s2_n1 == 4'd4)) begin
            sym_nxt = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
            cnt_nxt = s2_qm[8] ? (cnt_ext + bal) : (cnt_ext - bal);
          end else if ((!cnt[4] && (s2_n1 > 4'd4)) || (cnt[4] && (s2_n1 < 4'd4))) begin
            sym_nxt = {1'b1, s2_qm[8], ~s2_qm[7:0]};
            cnt_nxt = cnt_ext + two - bal;
          end else begin
            sym_nxt = {1'b0, s2_qm[8], s2_qm[7:0]};
            cnt_nxt = cnt_ext + bal - 6'sd2 + two;
          end
        end
      end

      always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
          cnt <= '0;
          sym <= TOKEN_00;
        end else begin
          cnt <= cnt_nxt[4:0];
          sym <= sym_nxt;
        end
      end

      assign ch_sym[ch] = sym;
    end
  endgenerate

  assign tmds_ch0_o = ch_sym[0];
  assign tmds_ch1_o = ch_sym[1];
  assign tmds_ch2_o = ch_sym[2];

endmodule
`default_nettype wire

// File: tb/tb_hdmi_tmds_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hdmi_tmds_encoder: directed vectors plus reference-model random run   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hdmi_tmds_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rgb;
  logic        de;
  logic        hs;
  logic        vs;
  logic [9:0]  a0, a1, a2;
  logic [9:0]  z0, z1, z2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hdmi_tmds_encoder #(.EXPAND_MODE(1)) dut_msb (
    .sys_clk_i(clk), .rst_i(rst), .rgb_i(rgb), .de_i(de),
    .hsync_i(hs), .vsync_i(vs),
    .tmds_ch0_o(a0), .tmds_ch1_o(a1), .tmds_ch2_o(a2)
  );

  hdmi_tmds_encoder #(.EXPAND_MODE(0)) dut_zero (
    .sys_clk_i(clk), .rst_i(rst), .rgb_i(rgb), .de_i(de),
    .hsync_i(hs), .vsync_i(vs),
    .tmds_ch0_o(z0), .tmds_ch1_o(z1), .tmds_ch2_o(z2)
  );

  typedef struct {
    logic        de;
    logic        vs;
    logic        hs;
    logic [15:0] rgb;
    logic [9:0]  e0;
    logic [9:0]  e12;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  int cnt_m [2][3];

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] get_out(input int m, input int ch);
    logic [9:0] v;
    case ({m[0], ch[1:0]})
      3'b000:  v = a0;
      3'b001:  v = a1;
      3'b010:  v = a2;
      3'b100:  v = z0;
      3'b101:  v = z1;
      default: v = z2;
    endcase
    return v;
  endfunction

  function automatic logic [23:0] expand(input int m, input logic [15:0] p);
    logic [4:0] r5, b5;
    logic [5:0] g5;
    r5 = p[15:11]; g5 = p[10:5]; b5 = p[4:0];
    if (m == 0) return {r5, r5[4:2], g5, g5[5:4], b5, b5[4:2]};
    return {r5, 3'b000, g5, 2'b00, b5, 3'b000};
  endfunction

  // Reference DVI encoder; m selects DUT (0 = MSB replicate, 1 = zero pad).
  function automatic logic [9:0] ref_enc(input int m, input int ch, input logic [7:0] d,
                                         input logic den, input logic [1:0] c);
    logic [7:0] q;
    logic       q8;
    int         n1d, n1q, n0q, cnt;
    logic [9:0] s;
    n1d = $countones(d);
    q8  = !((n1d > 4) || (n1d == 4 && d[0] == 1'b0));
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = q8 ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
    n1q = $countones(q);
    n0q = 8 - n1q;
    cnt = cnt_m[m][ch];
    if (!den) begin
      cnt = 0;
      case (c)
        2'b00:   s = 10'h354;
        2'b01:   s = 10'h0AB;
        2'b10:   s = 10'h154;
        default: s = 10'h2AB;
      endcase
    end else if (cnt == 0 || n1q == n0q) begin
      if (q8) begin s = {2'b01, q};  cnt = cnt + n1q - n0q; end
      else    begin s = {2'b10, ~q}; cnt = cnt + n0q - n1q; end
    end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
      s   = {1'b1, q8, ~q};
      cnt = cnt + (q8 ? 2 : 0) + n0q - n1q;
    end else begin
      s   = {1'b0, q8, q};
      cnt = cnt + n1q - n0q - (q8 ? 0 : 2);
    end
    cnt_m[m][ch] = cnt;
    return s;
  endfunction

  task automatic set_vec(input int i, input logic d, input logic v, input logic h,
                         input logic [15:0] p, input logic [9:0] e0, input logic [9:0] e12);
    tbl[i].de = d; tbl[i].vs = v; tbl[i].hs = h; tbl[i].rgb = p;
    tbl[i].e0 = e0; tbl[i].e12 = e12;
  endtask

  task automatic drive(input logic d, input logic v, input logic h, input logic [15:0] p);
    de = d; vs = v; hs = h; rgb = p;
  endtask

  logic [9:0] en  [2][3];
  logic [9:0] ed1 [2][3];
  logic [9:0] ed2 [2][3];
  logic [9:0] black_seq [10];

  initial begin
    black_seq = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100,
                  10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h100};
    set_vec(0, 1'b0, 1'b0, 1'b1, 16'h0000, 10'h0AB, 10'h354);
    set_vec(1, 1'b0, 1'b1, 1'b0, 16'h0000, 10'h154, 10'h354);
    set_vec(2, 1'b0, 1'b1, 1'b1, 16'h0000, 10'h2AB, 10'h354);
    set_vec(3, 1'b0, 1'b0, 1'b0, 16'h0000, 10'h354, 10'h354);
    for (int i = 0; i < 10; i++) set_vec(4 + i, 1'b1, 1'b0, 1'b0, 16'h0000, black_seq[i], black_seq[i]);
    set_vec(14, 1'b0, 1'b0, 1'b0, 16'h0000, 10'h354, 10'h354);
    for (int i = 0; i < 3; i++) set_vec(15 + i, 1'b1, 1'b0, 1'b0, 16'h0000, black_seq[i], black_seq[i]);
    set_vec(18, 1'b0, 1'b0, 1'b0, 16'h0000, 10'h354, 10'h354);
    for (int i = 0; i < 3; i++) set_vec(19 + i, 1'b1, 1'b0, 1'b0, 16'h0000, black_seq[i], black_seq[i]);
    // White straight after black (cnt=-6), sync ignored while de=1.
    set_vec(22, 1'b1, 1'b0, 1'b1, 16'hFFFF, 10'h0FF, 10'h0FF);
    set_vec(23, 1'b1, 1'b0, 1'b1, 16'hFFFF, 10'h200, 10'h200);
    set_vec(24, 1'b1, 1'b0, 1'b1, 16'hFFFF, 10'h0FF, 10'h0FF);
    set_vec(25, 1'b1, 1'b0, 1'b1, 16'hFFFF, 10'h0FF, 10'h0FF);
    set_vec(26, 1'b0, 1'b0, 1'b1, 16'h0000, 10'h0AB, 10'h354);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < 3; ch++) chk($sformatf("reset_m%0d_ch%0d", m, ch), get_out(m, ch), 10'h354);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_%0d_ch0", k), a0, 10'h354);
      chk($sformatf("idle_%0d_ch2", k), z2, 10'h354);
    end

    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) drive(tbl[i].de, tbl[i].vs, tbl[i].hs, tbl[i].rgb);
      else        drive(1'b0, 1'b0, 1'b0, 16'h0000);
      @(posedge clk); #1;
      if (i >= 2) begin
        chk($sformatf("vec%0d_ch0", i - 2), a0, tbl[i-2].e0);
        chk($sformatf("vec%0d_ch1", i - 2), a1, tbl[i-2].e12);
        chk($sformatf("vec%0d_ch2", i - 2), a2, tbl[i-2].e12);
      end
    end

    // White pixel expansion difference: zero pad gives B=R=0xF8, G=0xFC.
    for (int k = 0; k < 4; k++) begin
      if (k < 2) drive(1'b1, 1'b0, 1'b0, 16'hFFFF);
      else       drive(1'b0, 1'b0, 1'b0, 16'h0000);
      @(posedge clk); #1;
      if (k == 2) begin
        chk("white0_zero_ch0", z0, 10'h2FD);
        chk("white0_zero_ch1", z1, 10'h201);
        chk("white0_zero_ch2", z2, 10'h2FD);
        chk("white0_msb_ch0",  a0, 10'h200);
      end else if (k == 3) begin
        chk("white1_zero_ch0", z0, 10'h002);
        chk("white1_zero_ch1", z1, 10'h0FE);
        chk("white1_zero_ch2", z2, 10'h002);
        chk("white1_msb_ch0",  a0, 10'h0FF);
      end
    end

    // Reset during an active line.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < 3; ch++) chk($sformatf("midrst_m%0d_ch%0d", m, ch), get_out(m, ch), 10'h354);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst%0d_ch0", k), a0, (k < 2) ? 10'h354 : ((k == 2) ? 10'h100 : 10'h3FF));
      chk($sformatf("postrst%0d_z1", k),  z1, (k < 2) ? 10'h354 : ((k == 2) ? 10'h100 : 10'h3FF));
    end

    // Random pixels against the reference model; the first input is blanking.
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < 3; ch++) cnt_m[m][ch] = 0;
    for (int k = 0; k < 10000; k++) begin
      logic [23:0] x;
      drive((k == 0) ? 1'b0 : ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      for (int m = 0; m < 2; m++) begin
        x = expand(m, rgb);
        en[m][0] = ref_enc(m, 0, x[7:0],   de, {vs, hs});
        en[m][1] = ref_enc(m, 1, x[15:8],  de, 2'b00);
        en[m][2] = ref_enc(m, 2, x[23:16], de, 2'b00);
      end
      @(posedge clk); #1;
      if (k >= 2)
        for (int m = 0; m < 2; m++)
          for (int ch = 0; ch < 3; ch++)
            chk($sformatf("rand%0d_m%0d_ch%0d", k - 2, m, ch), get_out(m, ch), ed2[m][ch]);
      ed2 = ed1;
      ed1 = en;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
